alu_serial_ctrl: RTL and testbench
==================================

# alu_serial_ctrl

Bit-serial 24-bit ALU controller for the datapath. It latches two operands and an op code on a start handshake. Over 24 cycles it feeds one bit pair per cycle through a 1-bit ALU slice with an 8:1 result select, then shifts each selected output bit back into a 24-bit result register. It is the collecting end of the per-bit result select and serves as the area-reduced alternative to the parallel ALU on the CPU execute path.

## Interface
- No parameters; width fixed at 24 bits, bit count fixed at 24.
- Clock  in  1  single system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low; clears all state immediately when low.
- Start  in  1  request; sampled only in IDLE.
- Op  in  3  000 AND, 001 OR, 010 ADD, 011 SLT, 100 XOR, 101/110/111 reserved.
- BInvert  in  1  invert B bits and set carry-in to 1 (SUB, and required for SLT).
- A  in  24  operand A; latched on the accepted Start.
- B  in  24  operand B; latched on the accepted Start.
- Busy  out  1  high in RUN and DONE.
- Done  out  1  one-cycle pulse in DONE.
- Result  out  24  result register; held from DONE until the next accepted Start.
- CarryOut  out  1  final carry for ADD/SLT, 0 otherwise.
- Overflow  out  1  signed overflow for ADD/SLT, 0 otherwise.
- Zero  out  1  Result == 0.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on Start=1.
  - RUN → DONE when bit counter = 23.
  - DONE → IDLE unconditionally.
- On accept:
  - Latch A, B (B inverted when BInvert=1), Op, BInvert.
  - Counter = 0; carry = BInvert; Result = 0.
- Each RUN cycle operates on bit i = counter.
  - Slice computes and = a&b, or = a|b, sum = a^b^c, xor = a^b, less = 0; reserved inputs tie to 0.
  - The selected bit is shifted into Result MSB-first from the right, so Result[i] = selected bit after 24 cycles.
  - carry ← carry-out of bit i.
  - On i=23, record c23_in (carry into bit 23) and the final carry.
- On entry to DONE:
  - Overflow = c23_in ^ carry_out (ADD/SLT only).
  - SLT: Result = {23'b0, sum23 ^ Overflow}.
  - CarryOut is driven for ADD/SLT only.
  - Zero is computed from the final Result.
- Reserved ops produce Result = 0, CarryOut = 0, Overflow = 0, Zero = 1.
- Start while Busy is ignored and has no side effects. Operand and Op changes after accept have no effect.
- Reset low at any time (including mid-RUN): state goes to IDLE and every output goes to 0. The abandoned operation never produces Done.

## Timing
- Reset values: Busy=0, Done=0, Result=0x000000, CarryOut=0, Overflow=0, Zero=0. Zero is registered and updates only in DONE.
- Start accepted at edge k → Busy=1 from k.
- RUN covers edges k+1 … k+24; DONE is the state after edge k+24. Done, Result and flags are valid in that cycle.
- Latency from Start to Done is 25 cycles. Back-to-back throughput is one operation per 26 cycles (Start seen in the IDLE after DONE).
- Result and flags are stable from DONE until the next accepted Start. Result clears on accept.
- Start held continuously high restarts in every IDLE cycle.

## Structure
- Shared package/header:
  - Op code constants (OP_AND, OP_OR, OP_ADD, OP_SLT, OP_XOR).
  - FSM state encodings.
  - Data width constant 24.
- Sub-module alu_bit_slice (combinational): inputs a, b, cin, op[2:0]; outputs res and cout. It contains the 8:1 result select.
- The top level holds the FSM, the 5-bit counter, operand shift registers, the carry register and the result register.

## Test plan
- ADD: A=0x000001, B=0xFFFFFF, BInvert=0 → Done at cycle 25 after Start; Result=0x000000, CarryOut=1, Overflow=0, Zero=1.
- SUB: A=0x000005, B=0x000007, Op=010, BInvert=1 → Result=0xFFFFFE, CarryOut=0, Zero=0. Also A=0x7FFFFF − B=0xFFFFFF → Overflow=1.
- SLT: A=0x800000, B=0x000001, BInvert=1 → Result=0x000001. Swapped operands → Result=0x000000, Zero=1.
- Logic ops on A=0xF0F0F0, B=0x0FF00F:
  - AND → 0x00F000.
  - OR → 0xFFF0FF.
  - XOR → 0xFF00FF.
  - Op=110 → Result=0x000000, Zero=1.
- Start pulsed at cycle 10 of RUN with different operands → ignored; the original result is returned and exactly one Done occurs.
- Reset asserted low at cycle 12 of RUN → all outputs 0 immediately, no Done. After release, a new ADD 0x000002+0x000003 returns 0x000005.

Source files
------------

// File: rtl/alu_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU controller.
// Provides the op code constants, the FSM state encoding, the datapath width and the
// bit-counter width, plus a helper that tells whether an op uses the adder carry chain.
package alu_serial_ctrl_pkg;

  localparam int WIDTH = 24;
  localparam int CNT_W = 5;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ADD and SLT are the only ops whose carry/overflow flags are meaningful.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_bit_slice.sv
// One-bit ALU slice with an 8:1 result select; purely combinational (zero latency, no flow control).
// Ports: a, b, cin = operand bits and carry-in; op = result select;
//        res = selected result bit; cout = full-adder carry-out (valid for every op).
module alu_bit_slice
  import alu_serial_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       res,
  output logic       cout
);

  logic sum;

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

  // SLT contributes 0 per bit; the controller patches bit 0 after the last bit.
  // Reserved selects are tied to 0.
  always_comb begin
    res = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = sum;
      OP_SLT:  res = 1'b0;
      OP_XOR:  res = a ^ b;
      default: res = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial 24-bit ALU controller: latches operands on start, processes one bit per cycle.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+24; 26 cycles per op.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
// Ports: clk, rst_n (async active-low); start/op/b_invert/a/b = request;
//        busy, done (1-cycle pulse), result, carry_out, overflow, zero = registered outputs.
module alu_serial_ctrl
  import alu_serial_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             b_invert,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [2:0]       op_r;
  logic             carry;

  logic             s_res;
  logic             s_cout;
  logic             last_bit;
  logic             ovf;
  logic             sum_msb;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] final_res;

  // Operands are consumed LSB-first from bit 0 of the shift registers.
  alu_bit_slice u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .op   (op_r),
    .res  (s_res),
    .cout (s_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // On the last bit, carry holds the carry into bit 23.
  assign ovf      = carry ^ s_cout;
  assign sum_msb  = a_sh[0] ^ b_sh[0] ^ carry;
  // New bits enter at the MSB, so the bit computed first lands in result[0].
  assign shifted  = {s_res, result[WIDTH-1:1]};
  assign final_res = (op_r == OP_SLT) ? {{(WIDTH-1){1'b0}}, sum_msb ^ ovf} : shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      op_r      <= '0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b_invert ? ~b : b;
            op_r   <= op;
            carry  <= b_invert;  // +1 of the two's complement negate
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= s_cout;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            result    <= final_res;
            carry_out <= is_arith(op_r) ? s_cout : 1'b0;
            overflow  <= is_arith(op_r) ? ovf : 1'b0;
            zero      <= (final_res == '0);
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            result <= shifted;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: scoreboard of expected results, compared on done.
module tb_alu_serial_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic        b_invert;
  logic [23:0] a;
  logic [23:0] b;
  logic        busy;
  logic        done;
  logic [23:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  typedef struct packed {
    logic [23:0] res;
    logic        co;
    logic        ov;
    logic        z;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [23:0] last_res;

  alu_serial_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .b_invert  (b_invert),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on 24-bit two's complement values.
  function automatic exp_t model(input logic [23:0] ia, input logic [23:0] ib,
                                 input logic [2:0] iop, input logic ibi);
    logic [23:0] bb;
    logic [24:0] s;
    logic [23:0] lo;
    exp_t        e;
    bb   = ibi ? ~ib : ib;
    s    = {1'b0, ia} + {1'b0, bb} + 25'(ibi);
    lo   = {1'b0, ia[22:0]} + {1'b0, bb[22:0]} + 24'(ibi);
    e.co = 1'b0;
    e.ov = 1'b0;
    case (iop)
      3'b000: e.res = ia & bb;
      3'b001: e.res = ia | bb;
      3'b100: e.res = ia ^ bb;
      3'b010: begin
        e.res = s[23:0];
        e.co  = s[24];
        e.ov  = lo[23] ^ s[24];
      end
      3'b011: begin
        e.co  = s[24];
        e.ov  = lo[23] ^ s[24];
        e.res = {23'b0, s[23] ^ e.ov};
      end
      default: e.res = 24'h0;
    endcase
    e.z = (e.res == 24'h0);
    return e;
  endfunction

  // Called one time unit after a clock edge with the DUT idle.
  // poke > 0 pulses start with unrelated operands that many edges into RUN.
  task automatic run_op(input string tag, input logic [23:0] ia, input logic [23:0] ib,
                        input logic [2:0] iop, input logic ibi, input int poke);
    exp_t e;
    int   edges;
    a = ia; b = ib; op = iop; b_invert = ibi; start = 1'b1;
    sb.push_back(model(ia, ib, iop, ibi));
    @(posedge clk); #1;
    start = 1'b0;
    a = 24'($urandom); b = 24'($urandom); op = 3'($urandom); b_invert = 1'($urandom);
    chk({tag, "_busy"}, busy, 1);
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == poke) begin
        start = 1'b1; a = ~ia; b = ~ib; op = 3'b001;
      end else begin
        start = 1'b0;
      end
    end
    e = sb.pop_front();
    if (!done) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_latency"}, edges, 24);
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_cout"}, carry_out, e.co);
      chk({tag, "_ovf"}, overflow, e.ov);
      chk({tag, "_zero"}, zero, e.z);
      last_res = result;
    end
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_hold"}, result, e.res);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin : stim
    int d1;
    int d2;
    int extra;
    rst_n = 1'b0; start = 1'b0; op = 3'b0; b_invert = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", carry_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_zero", zero, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add", 24'h000001, 24'hFFFFFF, 3'b010, 1'b0, 0);
    chk("add_const", last_res, 24'h000000);
    run_op("sub", 24'h000005, 24'h000007, 3'b010, 1'b1, 0);
    chk("sub_const", last_res, 24'hFFFFFE);
    run_op("sub_ovf", 24'h7FFFFF, 24'hFFFFFF, 3'b010, 1'b1, 0);
    chk("sub_ovf_flag", overflow, 1);
    run_op("slt", 24'h800000, 24'h000001, 3'b011, 1'b1, 0);
    chk("slt_const", last_res, 24'h000001);
    run_op("slt_swap", 24'h000001, 24'h800000, 3'b011, 1'b1, 0);
    run_op("and", 24'hF0F0F0, 24'h0FF00F, 3'b000, 1'b0, 0);
    chk("and_const", last_res, 24'h00F000);
    run_op("or", 24'hF0F0F0, 24'h0FF00F, 3'b001, 1'b0, 0);
    chk("or_const", last_res, 24'hFFF0FF);
    run_op("xor", 24'hF0F0F0, 24'h0FF00F, 3'b100, 1'b0, 0);
    chk("xor_const", last_res, 24'hFF00FF);
    run_op("rsvd", 24'hF0F0F0, 24'h0FF00F, 3'b110, 1'b0, 0);

    // Start pulsed mid-run must be ignored and yield a single done.
    run_op("poke", 24'h123456, 24'h00ABCD, 3'b010, 1'b0, 10);
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk("poke_extra_done", extra, 0);
    chk("poke_idle", busy, 0);

    // Reset in the middle of RUN abandons the op.
    a = 24'h111111; b = 24'h222222; op = 3'b010; b_invert = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_flags", {carry_out, overflow, zero, done}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk("mid_rst_no_done", extra, 0);
    run_op("post_rst", 24'h000002, 24'h000003, 3'b010, 1'b0, 0);
    chk("post_rst_const", last_res, 24'h000005);

    for (int i = 0; i < 16; i++) begin
      run_op("rand", 24'($urandom), 24'($urandom), 3'($urandom_range(0, 7)),
             1'($urandom), 0);
    end

    // Start held high: back-to-back ops every 26 cycles.
    a = 24'h000010; b = 24'h000020; op = 3'b010; b_invert = 1'b0; start = 1'b1;
    d1 = -1; d2 = -1;
    for (int e = 1; e <= 80 && d2 < 0; e++) begin
      @(posedge clk); #1;
      if (done) begin
        if (d1 < 0) d1 = e;
        else d2 = e;
      end
    end
    start = 1'b0;
    chk("held_first_done", d1, 25);
    chk("held_spacing", d2 - d1, 26);
    chk("held_result", result, 24'h000030);
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
